// File: rtl/sipo_rx_if.sv
// Handshake/bus bundle between a serial source/consumer and the sipo_rx receiver.
interface sipo_rx_if #(
  parameter int unsigned W = 4
);
  logic         en;
  logic         sin;
  logic         dir;
  logic         ready;
  logic [W-1:0] q;
  logic         valid;
  logic         busy;
  logic         ovr;

  // Source/consumer side drives the serial line and the ready handshake.
  modport master (
    output en, sin, dir, ready,
    input  q, valid, busy, ovr
  );

  // Receiver side.
  modport slave (
    input  en, sin, dir, ready,
    output q, valid, busy, ovr
  );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: start-bit detect, W data bits MSB- or
// LSB-first, one output holding register with valid/ready and sticky overrun.
module sipo_rx #(
  parameter int unsigned W = 4
) (
  input logic         clk,
  input logic         rst,
  sipo_rx_if.slave    bus
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t          state;
  logic [W-1:0]    sr;
  logic [CW-1:0]   cnt;
  logic            dir_r;
  logic [W-1:0]    q_r;
  logic            valid_r;
  logic            busy_r;
  logic            ovr_r;

  logic [W-1:0]    sr_next_c;
  logic            last_c;
  logic            done_c;

  // Next shift-register value and frame-completion strobe.
  always_comb begin
    sr_next_c = sr;
    last_c    = (cnt == CW'(W - 1));
    done_c    = 1'b0;
    if (dir_r) begin
      sr_next_c = {bus.sin, sr[W-1:1]};
    end else begin
      sr_next_c = {sr[W-2:0], bus.sin};
    end
    done_c = (state == DATA) && bus.en && last_c;
  end

  // Frame FSM, shift register and output holding stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      dir_r   <= 1'b0;
      q_r     <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (bus.en) begin
        case (state)
          IDLE: begin
            if (bus.sin) begin
              state  <= DATA;
              cnt    <= '0;
              dir_r  <= bus.dir;
              busy_r <= 1'b1;
            end
          end
          DATA: begin
            sr  <= sr_next_c;
            cnt <= cnt + CW'(1);
            if (last_c) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end

      // A completing frame either loads q (slot free or being consumed) or overruns.
      if (done_c) begin
        if (!valid_r || bus.ready) begin
          q_r     <= sr_next_c;
          valid_r <= 1'b1;
        end else begin
          ovr_r <= 1'b1;
        end
      end else if (valid_r && bus.ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.q     = q_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.ovr   = ovr_r;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx with a per-cycle frame-level reference model.
module tb_sipo_rx;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;

  sipo_rx_if #(.W(W)) bus ();

  sipo_rx #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: collects the frame's bits, builds the word by bit position.
  logic         m_busy;
  logic         m_dir;
  logic         m_bits [W];
  int           m_nb;
  logic [W-1:0] m_q;
  logic         m_valid;
  logic         m_ovr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update on each posedge, then per-cycle comparison once the DUT settles.
  always @(posedge clk) begin
    logic         done;
    logic [W-1:0] word;
    done = 1'b0;
    word = '0;
    if (rst) begin
      m_busy  = 1'b0;
      m_dir   = 1'b0;
      m_nb    = 0;
      m_q     = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (bus.en) begin
        if (!m_busy) begin
          if (bus.sin) begin
            m_busy = 1'b1;
            m_nb   = 0;
            m_dir  = bus.dir;
          end
        end else begin
          m_bits[m_nb] = bus.sin;
          m_nb++;
          if (m_nb == W) begin
            for (int i = 0; i < W; i++) begin
              if (m_dir) word[i] = m_bits[i];
              else       word[W-1-i] = m_bits[i];
            end
            done   = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
      if (done) begin
        if (!m_valid || bus.ready) begin
          m_q     = word;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && bus.ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("cyc_q",     bus.q,            m_q);
    chk("cyc_valid", W'(bus.valid),    W'(m_valid));
    chk("cyc_busy",  W'(bus.busy),     W'(m_busy));
    chk("cyc_ovr",   W'(bus.ovr),      W'(m_ovr));
  end

  // Apply one cycle of inputs and advance to the following negedge.
  task automatic step(input logic r, input logic e, input logic s, input logic d, input logic rd);
    rst       = r;
    bus.en    = e;
    bus.sin   = s;
    bus.dir   = d;
    bus.ready = rd;
    @(negedge clk);
  endtask

  // Start bit plus W data bits, MSB of 'word' first, en held high.
  task automatic frame_msb(input logic [W-1:0] word, input logic rd_last);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, word[i], 1'b0, (i == 0) ? rd_last : 1'b0);
    end
  endtask

  initial begin
    logic seq [5];
    logic tdir;
    seq[0] = 1'b1; seq[1] = 1'b1; seq[2] = 1'b0; seq[3] = 1'b1; seq[4] = 1'b1;
    rst = 1'b1; bus.en = 1'b1; bus.sin = 1'b1; bus.dir = 1'b0; bus.ready = 1'b0;
    @(negedge clk);

    // Reset held with start-bit activity on the line.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_q", bus.q, 4'h0);
    chk("rst_valid", W'(bus.valid), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_ovr", W'(bus.ovr), W'(0));

    // MSB first, continuous strobe.
    step(1'b0, 1'b1, seq[0], 1'b0, 1'b0);
    chk("msb_busy_start", W'(bus.busy), W'(1));
    for (int i = 1; i < 5; i++) step(1'b0, 1'b1, seq[i], 1'b0, 1'b0);
    chk("msb_q", bus.q, 4'b1011);
    chk("msb_model_q", m_q, 4'b1011);
    chk("msb_valid", W'(bus.valid), W'(1));
    chk("msb_busy_end", W'(bus.busy), W'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("msb_consumed_valid", W'(bus.valid), W'(0));
    chk("msb_consumed_q", bus.q, 4'b1011);

    // LSB first with en gaps, dir toggling mid-frame, noise on gap cycles.
    tdir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("lsb_valid_before", W'(bus.valid), W'(0));
      step(1'b0, 1'b1, seq[i], tdir, 1'b0);
      tdir = ~tdir;
      if (i < 4) begin
        step(1'b0, 1'b0, ~seq[i], tdir, 1'b0);
        tdir = ~tdir;
      end
    end
    chk("lsb_q", bus.q, 4'b1101);
    chk("lsb_model_q", m_q, 4'b1101);
    chk("lsb_valid", W'(bus.valid), W'(1));

    // Idle noise: no start bits, word stays pending.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_busy", W'(bus.busy), W'(0));
    chk("idle_q", bus.q, 4'b1101);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("idle_consume_valid", W'(bus.valid), W'(0));

    // Overrun: two back-to-back frames, nobody consumes.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame_msb(4'hA, 1'b0);
    frame_msb(4'h5, 1'b0);
    chk("ovr_q", bus.q, 4'hA);
    chk("ovr_valid", W'(bus.valid), W'(1));
    chk("ovr_flag", W'(bus.ovr), W'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ovr_sticky", W'(bus.ovr), W'(1));

    // Consume coincident with completion is not an overrun.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame_msb(4'hA, 1'b0);
    frame_msb(4'h5, 1'b1);
    chk("sim_q", bus.q, 4'h5);
    chk("sim_valid", W'(bus.valid), W'(1));
    chk("sim_ovr", W'(bus.ovr), W'(0));

    // Reset mid-frame, then a clean frame.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_busy_before", W'(bus.busy), W'(1));
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_busy_rst", W'(bus.busy), W'(0));
    frame_msb(4'h9, 1'b0);
    chk("abort_q", bus.q, 4'h9);
    chk("abort_model_q", m_q, 4'h9);
    chk("abort_valid", W'(bus.valid), W'(1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
